// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin grant,
// grant locked for the whole CYC, and an outstanding-request limit.
module wb_arbiter2 #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack,
    output logic          m0_stall,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack,
    output logic          m1_stall,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    input  logic          s_stall
);

    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic          full;
    logic          owner;
    logic          own_cyc, own_stb, own_we;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic          accept;
    logic          own_ack, own_stall;

    assign full = (cnt == CW'(MAX_OUT));

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_o   = '0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_stall  = 1'b1;
        m1_stall  = 1'b1;
        state_nx  = state;
        last_nx   = last;
        cnt_nx    = cnt;
        accept    = 1'b0;
        own_ack   = 1'b0;
        own_stall = 1'b1;
        owner     = (state == OWN1);
        own_cyc   = owner ? m1_cyc   : m0_cyc;
        own_stb   = owner ? m1_stb   : m0_stb;
        own_we    = owner ? m1_we    : m0_we;
        own_adr   = owner ? m1_adr   : m0_adr;
        own_dat   = owner ? m1_dat_i : m0_dat_i;

        if (state == IDLE) begin
            cnt_nx = '0;
            if (m0_cyc && m1_cyc)
                state_nx = last ? OWN0 : OWN1;
            else if (m0_cyc)
                state_nx = OWN0;
            else if (m1_cyc)
                state_nx = OWN1;
        end else begin
            s_cyc     = own_cyc;
            s_stb     = own_stb & ~full;
            s_we      = own_we;
            s_adr     = own_adr;
            s_dat_o   = own_dat;
            accept    = s_stb & ~s_stall;
            own_stall = s_stall | full;
            // Gated by the owner's cyc so acks for an abandoned cycle never reach it.
            own_ack   = s_ack & own_cyc;
            if (owner) begin
                m1_ack   = own_ack;
                m1_stall = own_stall;
                m1_dat_o = s_dat_i;
            end else begin
                m0_ack   = own_ack;
                m0_stall = own_stall;
                m0_dat_o = s_dat_i;
            end

            if (!own_cyc) begin
                state_nx = IDLE;
                last_nx  = owner;
                cnt_nx   = '0;
            end else begin
                unique case ({accept, s_ack})
                    2'b10:   cnt_nx = cnt + CW'(1);
                    2'b01:   cnt_nx = (cnt == '0) ? '0 : cnt - CW'(1);
                    default: cnt_nx = cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule
